// File: rtl/stream_multiplier_pipe.sv
// Signed two-stream join-multiply with arithmetic shift and saturation, LATENCY-deep lockstep pipeline.
// Optional round-half-up before the shift when STREAM_MULTIPLIER_PIPE_ROUND_EN is defined.
module stream_multiplier_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = DATA_WIDTH - 1,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] data_0_i_tdata,
  input  logic                  data_0_i_tvalid,
  output logic                  data_0_i_tready,
  input  logic [DATA_WIDTH-1:0] data_1_i_tdata,
  input  logic                  data_1_i_tvalid,
  output logic                  data_1_i_tready,
  output logic [OUT_WIDTH-1:0]  data_o_tdata,
  output logic                  data_o_tvalid,
  input  logic                  data_o_tready,
  output logic                  data_o_tuser
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int NS = LATENCY - 1;
  // Compare width covers both the one-bit-grown product and the output range.
  localparam int CW = (PW + 1 > OUT_WIDTH + 1) ? PW + 1 : OUT_WIDTH + 1;
  localparam logic signed [CW-1:0] OMAX = (CW'(1) <<< (OUT_WIDTH - 1)) - CW'(1);
  localparam logic signed [CW-1:0] OMIN = ~OMAX;
`ifdef STREAM_MULTIPLIER_PIPE_ROUND_EN
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [CW-1:0] RND = (SHIFT > 0) ? (CW'(1) <<< RS) : '0;
`endif

  logic signed [DATA_WIDTH-1:0] a_s, b_s;
  logic signed [PW-1:0]         prod_q [1:NS];
  logic signed [PW-1:0]         prod_d [1:NS];
  logic [NS:1]                  vld_q, vld_d;
  logic [OUT_WIDTH-1:0]         tdata_q, tdata_d;
  logic                         tuser_q, tuser_d;
  logic                         tvalid_q, tvalid_d;
  logic                         adv, accept;
  logic signed [CW-1:0]         ext_w, sh_w;
  logic                         sat_hi, sat_lo;

  assign a_s = data_0_i_tdata;
  assign b_s = data_1_i_tdata;

  always_comb begin
    adv    = data_o_tready | ~tvalid_q;
    accept = adv & data_0_i_tvalid & data_1_i_tvalid;
    prod_d[1] = PW'(a_s) * PW'(b_s);
    vld_d[1]  = accept;
    for (int i = 2; i <= NS; i++) begin
      prod_d[i] = prod_q[i-1];
      vld_d[i]  = vld_q[i-1];
    end
  end

  always_comb begin
    ext_w = CW'(prod_q[NS]);
`ifdef STREAM_MULTIPLIER_PIPE_ROUND_EN
    ext_w = ext_w + RND;
`endif
    sh_w     = ext_w >>> SHIFT;
    sat_hi   = sh_w > OMAX;
    sat_lo   = sh_w < OMIN;
    tvalid_d = vld_q[NS];
    tuser_d  = sat_hi | sat_lo;
    if (sat_hi)      tdata_d = OMAX[OUT_WIDTH-1:0];
    else if (sat_lo) tdata_d = OMIN[OUT_WIDTH-1:0];
    else             tdata_d = sh_w[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      for (int i = 1; i <= NS; i++) prod_q[i] <= '0;
    end else if (adv) begin
      vld_q    <= vld_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      for (int i = 1; i <= NS; i++) prod_q[i] <= prod_d[i];
    end
  end

  assign data_0_i_tready = adv & data_1_i_tvalid;
  assign data_1_i_tready = adv & data_0_i_tvalid;
  assign data_o_tdata    = tdata_q;
  assign data_o_tvalid   = tvalid_q;
  assign data_o_tuser    = tuser_q;

endmodule
